// File: rtl/iob_regfile_wr_ctrl.sv
// Write sequencer for the register-file write port: turns one command into a
// run of consecutive writes, either from a data stream or repeating a fill value.
module iob_regfile_wr_ctrl #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 21
) (
    input  logic              clk_i,
    input  logic              arst_n_i,
    input  logic              cke_i,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic [ADDR_W-1:0] cmd_addr_i,
    input  logic [ADDR_W:0]   cmd_len_i,
    input  logic              cmd_fill_i,
    input  logic [DATA_W-1:0] fill_data_i,
    input  logic              data_valid_i,
    output logic              data_ready_o,
    input  logic [DATA_W-1:0] data_i,
    output logic              w_cke_o,
    output logic [ADDR_W-1:0] w_addr_o,
    output logic [DATA_W-1:0] w_data_o,
    output logic              busy_o,
    output logic              done_o
);

    typedef enum logic [1:0] {IDLE, STREAM, FILL, DONE} state_t;

    localparam logic [ADDR_W:0] LEN_ONE = (ADDR_W + 1)'(1);

    state_t              state;
    logic [ADDR_W-1:0]   addr;
    logic [ADDR_W:0]     remaining;
    logic [DATA_W-1:0]   fill_val;

    // Handshake readiness depends on state alone, so no input-to-output paths.
    assign cmd_ready_o  = (state == IDLE);
    assign data_ready_o = (state == STREAM);
    assign busy_o       = (state != IDLE);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state     <= IDLE;
            addr      <= '0;
            remaining <= '0;
            fill_val  <= '0;
            w_cke_o   <= 1'b0;
            w_addr_o  <= '0;
            w_data_o  <= '0;
            done_o    <= 1'b0;
        end else if (cke_i) begin
            // Strobe and done default low; address/data hold their last write.
            w_cke_o <= 1'b0;
            done_o  <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid_i) begin
                        addr      <= cmd_addr_i;
                        remaining <= cmd_len_i;
                        fill_val  <= fill_data_i;
                        if (cmd_len_i == '0) begin
                            state  <= DONE;
                            done_o <= 1'b1;
                        end else begin
                            state <= cmd_fill_i ? FILL : STREAM;
                        end
                    end
                end
                STREAM: begin
                    if (data_valid_i) begin
                        w_cke_o   <= 1'b1;
                        w_addr_o  <= addr;
                        w_data_o  <= data_i;
                        addr      <= addr + 1'b1;
                        remaining <= remaining - 1'b1;
                        if (remaining == LEN_ONE) begin
                            state  <= DONE;
                            done_o <= 1'b1;
                        end
                    end
                end
                FILL: begin
                    w_cke_o   <= 1'b1;
                    w_addr_o  <= addr;
                    w_data_o  <= fill_val;
                    addr      <= addr + 1'b1;
                    remaining <= remaining - 1'b1;
                    if (remaining == LEN_ONE) begin
                        state  <= DONE;
                        done_o <= 1'b1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
